seq_comparator: RTL and testbench

Parametrised, multi-cycle magnitude comparator that extends the existing 2-bit combinational gt/eq/lt comparator to arbitrary operand widths. Operands are compared MSB-first, DIGIT bits per clock, and the scan terminates early at the first differing digit. The block has valid/ready handshakes on both sides so it can sit between pipelined datapath stages. It returns a registered one-hot gt/eq/lt result.

---
 rtl/seq_comparator_pkg.sv | 20 ++
 rtl/seq_comparator_cmp_digit.sv | 18 +
 rtl/seq_comparator.sv | 121 ++++++++++++
 tb/tb_seq_comparator.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_comparator_pkg.sv
// Shared types and result encodings for the sequential magnitude comparator.
package seq_comparator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    // Result encodings follow the {gt, eq, lt} output order.
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

    function automatic logic [2:0] pack_res(input logic gt, input logic eq, input logic lt);
        return {gt, eq, lt};
    endfunction

endpackage

// File: rtl/seq_comparator_cmp_digit.sv
// Combinational magnitude comparison of one DIGIT-wide digit pair.
module cmp_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    always_comb begin
        gt = (a > b);
        eq = (a == b);
        lt = (a < b);
    end

endmodule

// File: rtl/seq_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, early exit.
// Build option: SEQ_COMPARATOR_SIGNED_EN selects two's-complement operands.
module seq_comparator
    import seq_comparator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 a,
    input  logic [WIDTH-1:0]                 b,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             a_gt_b,
    output logic                             a_eq_b,
    output logic                             a_lt_b,
    output logic [$clog2(WIDTH/DIGIT):0]     digits_used
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-1:0] cap_a, cap_b;
    logic [2:0]       cmp_q;
    logic             cmp_vld;
    logic [CW-1:0]    k_q;
    logic [2:0]       res_q;
    logic [CW-1:0]    dused_q;
    logic             d_gt, d_eq, d_lt;
    logic             last_digit;
    logic             decide;

`ifdef SEQ_COMPARATOR_SIGNED_EN
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        cap_a = {~a[WIDTH-1], a[WIDTH-2:0]};
        cap_b = {~b[WIDTH-1], b[WIDTH-2:0]};
    end
`else
    always_comb begin
        cap_a = a;
        cap_b = b;
    end
`endif

    cmp_digit #(.DIGIT(DIGIT)) u_cmp_digit (
        .a  (a_sh[WIDTH-1 -: DIGIT]),
        .b  (b_sh[WIDTH-1 -: DIGIT]),
        .gt (d_gt),
        .eq (d_eq),
        .lt (d_lt)
    );

    always_comb begin
        last_digit = (k_q == CW'(N - 1));
        decide     = cmp_vld && ((cmp_q != RES_EQ) || last_digit);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SCAN;
            SCAN:    if (decide) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The digit compare is registered: cmp_q holds the verdict for digit k_q,
    // while the shift registers already present digit k_q+1 to cmp_digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            cmp_q   <= RES_NONE;
            cmp_vld <= 1'b0;
            k_q     <= '0;
            res_q   <= RES_NONE;
            dused_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= cap_a;
                        b_sh    <= cap_b;
                        k_q     <= '0;
                        cmp_vld <= 1'b0;
                    end
                end
                SCAN: begin
                    a_sh    <= a_sh << DIGIT;
                    b_sh    <= b_sh << DIGIT;
                    cmp_q   <= pack_res(d_gt, d_eq, d_lt);
                    cmp_vld <= 1'b1;
                    if (decide) begin
                        res_q   <= cmp_q;
                        dused_q <= k_q + CW'(1);
                    end else if (cmp_vld) begin
                        k_q <= k_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready                 = (state_q == IDLE);
        out_valid                = (state_q == DONE);
        {a_gt_b, a_eq_b, a_lt_b} = res_q;
        digits_used              = dused_q;
    end

endmodule

// File: tb/tb_seq_comparator.sv
// Scoreboard bench for seq_comparator: 8-bit/2-bit-digit and 16-bit/4-bit-digit instances.
module tb_seq_comparator;
    import seq_comparator_pkg::*;

`ifdef SEQ_COMPARATOR_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    typedef struct {
        logic [2:0]  res;
        int unsigned d;
        int unsigned t0;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  a, b;
    logic        a_gt_b, a_eq_b, a_lt_b;
    logic [2:0]  digits_used;
    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [15:0] w_a, w_b;
    logic        w_gt, w_eq, w_lt;
    logic [2:0]  w_digits_used;

    exp_t        q8[$];
    exp_t        q16[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        prev_ov8 = 1'b0;
    logic        prev_ov16 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_comparator #(.WIDTH(8), .DIGIT(2)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .a_gt_b(a_gt_b), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b), .digits_used(digits_used)
    );

    seq_comparator #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .a_gt_b(w_gt), .a_eq_b(w_eq), .a_lt_b(w_lt), .digits_used(w_digits_used)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Monitors: latency on out_valid rise, result on handshake.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && !prev_ov8) begin
            if (q8.size() == 0) timeout("w8_unexpected_out_valid");
            else chk("w8_latency", cyc - q8[0].t0, q8[0].d + 1);
        end
        if (out_valid && out_ready && q8.size() > 0) begin
            e = q8.pop_front();
            chk("w8_flags", {a_gt_b, a_eq_b, a_lt_b}, e.res);
            chk("w8_digits_used", digits_used, e.d);
        end
        prev_ov8 = out_valid;
    end

    always @(negedge clk) begin
        exp_t e;
        if (w_out_valid && !prev_ov16) begin
            if (q16.size() == 0) timeout("w16_unexpected_out_valid");
            else chk("w16_latency", cyc - q16[0].t0, q16[0].d + 1);
        end
        if (w_out_valid && w_out_ready && q16.size() > 0) begin
            e = q16.pop_front();
            chk("w16_flags", {w_gt, w_eq, w_lt}, e.res);
            chk("w16_digits_used", w_digits_used, e.d);
        end
        prev_ov16 = w_out_valid;
    end

    task automatic send(input bit wide, input logic [15:0] av, input logic [15:0] bv,
                        input logic [2:0] res, input int unsigned d, input bit push);
        int unsigned n = 0;
        exp_t e;
        @(negedge clk);
        while (!(wide ? w_in_ready : in_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!(wide ? w_in_ready : in_ready)) begin
            timeout("accept_wait");
            return;
        end
        if (wide) begin w_a = av; w_b = bv; w_in_valid = 1'b1; end
        else begin a = av[7:0]; b = bv[7:0]; in_valid = 1'b1; end
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        w_in_valid = 1'b0;
        e.res = res;
        e.d   = d;
        e.t0  = cyc;
        if (push) begin
            if (wide) q16.push_back(e);
            else q8.push_back(e);
        end
    endtask

    task automatic wait_out8(input string name);
        int unsigned n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) timeout(name);
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((q8.size() != 0 || q16.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q8.size() != 0 || q16.size() != 0) timeout("drain");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        w_in_valid = 1'b0; w_out_ready = 1'b1; w_a = '0; w_b = '0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_flags", {a_gt_b, a_eq_b, a_lt_b}, RES_NONE);
        chk("reset_digits_used", digits_used, 0);
        chk("reset_w16_in_ready", w_in_ready, 1);
        chk("reset_w16_out_valid", w_out_valid, 0);
        rst = 1'b0;

        // Top digit decides; one-cycle pulse with out_ready already high.
        send(1'b0, 16'h00C0, 16'h0040, SGN ? RES_LT : RES_GT, 1, 1'b1);
        wait_out8("pulse_wait");
        @(negedge clk);
        chk("pulse_out_valid_dropped", out_valid, 0);
        chk("pulse_in_ready_back", in_ready, 1);

        send(1'b0, 16'h005A, 16'h005A, RES_EQ, 4, 1'b1);
        send(1'b0, 16'h0000, 16'h0002, RES_LT, 4, 1'b1);
        send(1'b0, 16'h0010, 16'h0020, RES_LT, 2, 1'b1);
        send(1'b0, 16'h00FF, 16'h0001, SGN ? RES_LT : RES_GT, 1, 1'b1);
        send(1'b0, 16'h0080, 16'h0001, SGN ? RES_LT : RES_GT, 1, 1'b1);
        drain();

        // Reset during the scan discards the transaction.
        send(1'b0, 16'h0000, 16'h0001, RES_LT, 4, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_flags", {a_gt_b, a_eq_b, a_lt_b}, RES_NONE);
        chk("midrst_digits_used", digits_used, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrst_no_out_valid", out_valid, 0);
        send(1'b0, 16'h0003, 16'h0001, RES_GT, 4, 1'b1);
        drain();

        // Backpressure: result held, new operands ignored.
        out_ready = 1'b0;
        send(1'b0, 16'h004B, 16'h004C, RES_LT, 3, 1'b1);
        wait_out8("bp_wait");
        a = 8'hFF; b = 8'h00; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_flags", {a_gt_b, a_eq_b, a_lt_b}, RES_LT);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);

        send(1'b1, 16'h1234, 16'h1235, RES_LT, 4, 1'b1);
        send(1'b1, 16'h8000, 16'h7FFF, SGN ? RES_LT : RES_GT, 1, 1'b1);
        send(1'b1, 16'hABCD, 16'hABCD, RES_EQ, 4, 1'b1);
        drain();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
